// File: rtl/nspi_pkg.sv
// Shared definitions for the nspi transmitter datapath: sequencer state
// encoding and channel-slice helpers used to address packed channel words.
package nspi_pkg;

    localparam int NSPI_CHANNELS = 3;
    localparam int NSPI_SPI_SIZE = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_WAIT_READY,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    // Channel ch of a packed word occupies [chan_lsb(ch, size) +: size].
    function automatic int chan_lsb(input int ch, input int size);
        return ch * size;
    endfunction

endpackage

// File: rtl/nspi_frame_sequencer.sv
// Streams one frame of channel words from the frame RAM into nspi_tx, one
// handshaked transfer per byte slot, then idles for a latch gap.
module nspi_frame_sequencer
    import nspi_pkg::*;
#(
    parameter int CHANNEL_NUMBER  = NSPI_CHANNELS,
    parameter int SPI_SIZE        = NSPI_SPI_SIZE,
    parameter int BYTES_PER_FRAME = 384,
    parameter int LATCH_CYCLES    = 16,
    localparam int ADDR_WIDTH     = $clog2(BYTES_PER_FRAME),
    localparam int DATA_WIDTH     = SPI_SIZE * CHANNEL_NUMBER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] O_data_flat,
    output logic                  start_tx,
    input  logic                  tx_finish
);

    localparam int GAP_WIDTH = $clog2(LATCH_CYCLES + 1);

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [GAP_WIDTH-1:0]  gap_cnt;

    wire last_word = (word_idx == ADDR_WIDTH'(BYTES_PER_FRAME - 1));
    wire gap_end   = (gap_cnt == GAP_WIDTH'(LATCH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_idx    <= '0;
            gap_cnt     <= '0;
            O_data_flat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        word_idx <= '0;
                        state    <= ST_READ;
                    end
                end
                ST_READ: state <= ST_LOAD;
                ST_LOAD: begin
                    // RAM data arrives one cycle after the strobe; no bit reordering here.
                    O_data_flat <= mem_rd_data;
                    state       <= ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (tx_finish) state <= ST_START;
                end
                ST_START: begin
                    // Hold the request until the transmitter acknowledges by going busy.
                    if (!tx_finish) state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (tx_finish) begin
                        if (last_word) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        gap_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode; the word index only moves on READ entry, so it doubles as the held address.
    assign frame_busy  = (state != ST_IDLE);
    assign frame_done  = (state == ST_DONE);
    assign mem_rd_en   = (state == ST_READ);
    assign mem_rd_addr = word_idx;
    assign start_tx    = (state == ST_START);

endmodule
